// File: rtl/i2s_tdm_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tdm_tx_engine
// Brief    : Playback serializer, one AXI4-Stream beat per audio frame, driving
//            codec bclk / LR clock / data as master in I2S, LJ or TDM framing.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tdm_tx_engine #(
   parameter int DATA_WIDTH   = 24,
   parameter int SLOT_WIDTH   = 32,
   parameter int NUM_CHANNELS = 2,
   parameter int BCLK_DIV     = 4
) (
   input  logic                               board_clk,
   input  logic                               reset,
   input  logic                               enable,
   input  logic [1:0]                         mode,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                               s_axis_tvalid,
   output logic                               s_axis_tready,
   output logic                               ac_bclk,
   output logic                               ac_pblrc,
   output logic                               ac_pbdat,
   output logic                               frame_start,
   output logic                               underrun,
   output logic [15:0]                        underrun_count
);

   localparam int C_FRAME_BITS = NUM_CHANNELS * SLOT_WIDTH;
   localparam int C_DIV_W      = $clog2(BCLK_DIV);
   localparam int C_BIT_W      = $clog2(C_FRAME_BITS);
   localparam bit C_FORCE_TDM  = (NUM_CHANNELS % 2) != 0;

   localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(BCLK_DIV - 1);
   localparam logic [C_DIV_W-1:0] C_DIV_HALF = C_DIV_W'(BCLK_DIV / 2);
   localparam logic [C_BIT_W-1:0] C_BIT_LAST = C_BIT_W'(C_FRAME_BITS - 1);
   localparam logic [C_BIT_W-1:0] C_BIT_HALF = C_BIT_W'(C_FRAME_BITS / 2);

   localparam logic [1:0] C_MODE_I2S = 2'd0;
   localparam logic [1:0] C_MODE_LJ  = 2'd1;
   localparam logic [1:0] C_MODE_TDM = 2'd2;

   logic [NUM_CHANNELS*DATA_WIDTH-1:0] r_hold;
   logic                               r_full;
   logic [C_FRAME_BITS-1:0]            r_shift;
   logic [C_DIV_W-1:0]                 r_div;
   logic [C_BIT_W-1:0]                 r_bit;
   logic                               r_running;
   logic [1:0]                         r_mode;

   logic [C_FRAME_BITS-1:0] w_frame;
   logic [C_FRAME_BITS-1:0] w_load_val;
   logic [C_DIV_W-1:0]      w_div_next;
   logic [C_BIT_W-1:0]      w_bit_inc;
   logic [1:0]              w_mode_in;
   logic [1:0]              w_mode_cur;
   logic                    w_accept;
   logic                    w_load;
   logic                    w_adv;
   logic                    w_full_next;

   function automatic logic [1:0] eff_mode(input logic [1:0] m);
      if (C_FORCE_TDM)      return C_MODE_TDM;
      else if (m == 2'd3)   return C_MODE_I2S;
      else                  return m;
   endfunction

   // LR level for the bit index b that is about to appear on ac_pbdat.
   function automatic logic lrc_for(input logic [1:0] m, input logic [C_BIT_W-1:0] b);
      logic [C_BIT_W-1:0] nb;
      nb = (b == C_BIT_LAST) ? '0 : b + 1'b1;
      case (m)
         C_MODE_LJ:  return b < C_BIT_HALF;
         C_MODE_TDM: return b == '0;
         default:    return nb >= C_BIT_HALF;
      endcase
   endfunction

   // Each slot is the sample left-aligned with zero padding; channel 0 goes out first.
   for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_slot
      assign w_frame[C_FRAME_BITS-1-k*SLOT_WIDTH -: SLOT_WIDTH] =
         SLOT_WIDTH'(r_hold[k*DATA_WIDTH +: DATA_WIDTH]) << (SLOT_WIDTH - DATA_WIDTH);
   end

   assign w_load_val  = r_full ? w_frame : '0;
   assign w_accept    = s_axis_tvalid && s_axis_tready;
   assign w_load      = enable && (!r_running || (r_div == C_DIV_LAST && r_bit == C_BIT_LAST));
   assign w_adv       = enable && r_running && (r_div == C_DIV_LAST);
   assign w_full_next = w_accept || (r_full && !w_load);
   assign w_div_next  = (!r_running || r_div == C_DIV_LAST) ? '0 : r_div + 1'b1;
   assign w_bit_inc   = r_bit + 1'b1;
   assign w_mode_in   = eff_mode(mode);
   assign w_mode_cur  = r_running ? r_mode : w_mode_in;

   always_ff @(posedge board_clk) begin
      if (reset) begin
         r_hold         <= '0;
         r_full         <= 1'b0;
         r_shift        <= '0;
         r_div          <= '0;
         r_bit          <= '0;
         r_running      <= 1'b0;
         r_mode         <= C_MODE_I2S;
         s_axis_tready  <= 1'b1;
         ac_bclk        <= 1'b0;
         ac_pblrc       <= 1'b1;
         ac_pbdat       <= 1'b0;
         frame_start    <= 1'b0;
         underrun       <= 1'b0;
         underrun_count <= '0;
      end else begin
         frame_start <= 1'b0;
         underrun    <= 1'b0;

         // A beat landing on a load cycle survives for the following frame.
         if (w_accept) r_hold <= s_axis_tdata;
         r_full        <= w_full_next;
         s_axis_tready <= !w_full_next;

         if (!enable) begin
            r_running <= 1'b0;
            r_div     <= '0;
            r_bit     <= '0;
            r_mode    <= w_mode_in;
            ac_bclk   <= 1'b0;
            ac_pbdat  <= 1'b0;
            ac_pblrc  <= (w_mode_in == C_MODE_I2S);
         end else begin
            r_running <= 1'b1;
            r_mode    <= w_mode_cur;
            r_div     <= w_div_next;
            ac_bclk   <= (w_div_next >= C_DIV_HALF);
            if (w_load) begin
               r_bit       <= '0;
               r_shift     <= w_load_val << 1;
               ac_pbdat    <= w_load_val[C_FRAME_BITS-1];
               ac_pblrc    <= lrc_for(w_mode_cur, '0);
               frame_start <= 1'b1;
               if (!r_full) begin
                  underrun <= 1'b1;
                  if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
               end
            end else if (w_adv) begin
               r_bit    <= w_bit_inc;
               r_shift  <= r_shift << 1;
               ac_pbdat <= r_shift[C_FRAME_BITS-1];
               ac_pblrc <= lrc_for(r_mode, w_bit_inc);
            end
         end
      end
   end

endmodule
`default_nettype wire
